// File: rtl/population_rate_counter.sv
// Serial population spike counter with a sliding-window firing-rate total.
// Each accepted sweep is counted LANES bits per clock and folded into a WIN-deep ring sum.
//
//   state  | meaning
//   IDLE   | waiting for pop_valid; snapshot population_in on accept
//   COUNT  | accumulate popcount of one LANES-wide chunk per cycle
//   UPDATE | publish frame_count, update ring and window_sum
module population_rate_counter #(
   parameter int N     = 128,
   parameter int LANES = 8,
   parameter int WIN   = 16,
   parameter int CW    = $clog2(N + 1),
   parameter int SW    = $clog2(N * WIN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  population_in,
   input  logic          pop_valid,
   output logic [CW-1:0] frame_count,
   output logic [SW-1:0] window_sum,
   output logic          out_valid,
   output logic          busy,
   output logic          window_full,
   output logic          overflow
);

   localparam int CHUNKS = N / LANES;
   localparam int CHW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int LW     = $clog2(LANES + 1);
   localparam int PW     = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int FW     = $clog2(WIN + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] COUNT  = 2'd1;
   localparam logic [1:0] UPDATE = 2'd2;

   localparam logic [CHW-1:0] CHUNK_LAST = CHW'(CHUNKS - 1);
   localparam logic [FW-1:0]  FRAMES_MAX = FW'(WIN);

   logic [1:0]     state;
   logic [N-1:0]   shadow;
   logic [CHW-1:0] chunk;
   logic [CW-1:0]  acc;
   logic [CW-1:0]  ring [WIN];
   logic [PW-1:0]  wr_ptr;
   logic [FW-1:0]  frames_seen;
   logic [LANES-1:0] chunk_bits;
   logic [LW-1:0]  lane_cnt;

   assign chunk_bits  = shadow[int'(chunk) * LANES +: LANES];
   assign busy        = (state != IDLE);
   assign window_full = (frames_seen == FRAMES_MAX);

   always_comb begin
      lane_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_cnt = lane_cnt + {{(LW - 1){1'b0}}, chunk_bits[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         shadow      <= '0;
         chunk       <= '0;
         acc         <= '0;
         wr_ptr      <= '0;
         frames_seen <= '0;
         frame_count <= '0;
         window_sum  <= '0;
         out_valid   <= 1'b0;
         overflow    <= 1'b0;
         for (int i = 0; i < WIN; i++) begin
            ring[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         // Strobes arriving mid-sweep are lost; flag it so the pool timing can be diagnosed.
         if (pop_valid && (state != IDLE)) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (pop_valid) begin
                  shadow <= population_in;
                  acc    <= '0;
                  chunk  <= '0;
                  state  <= COUNT;
               end
            end
            COUNT: begin
               acc   <= acc + {{(CW - LW){1'b0}}, lane_cnt};
               chunk <= chunk + 1'b1;
               if (chunk == CHUNK_LAST) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               // Replacing the oldest entry keeps window_sum equal to the ring total.
               window_sum   <= window_sum + {{(SW - CW){1'b0}}, acc}
                                          - {{(SW - CW){1'b0}}, ring[wr_ptr]};
               ring[wr_ptr] <= acc;
               wr_ptr       <= wr_ptr + 1'b1;
               frame_count  <= acc;
               out_valid    <= 1'b1;
               if (frames_seen != FRAMES_MAX) begin
                  frames_seen <= frames_seen + 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
